// File: rtl/mmio_timer_pkg.sv
// Shared constants and types for the memory-mapped timer responder.
// Register offsets cover the optional PSC register enabled by MMIO_TIMER_PRESCALE_EN.
package mmio_timer_pkg;

  localparam int unsigned REG_W = 32;
  localparam int unsigned PSC_W = 16;

  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_LOAD  = 8'h04;
  localparam logic [7:0] OFF_COUNT = 8'h08;
  localparam logic [7:0] OFF_STAT  = 8'h0C;
  localparam logic [7:0] OFF_PSC   = 8'h10;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AR   = 1;
  localparam int unsigned CTRL_IE   = 2;
  localparam int unsigned STAT_PEND = 0;

  // Packed so that bit 0 is en, matching the CTRL register layout
  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/mmio_timer_resp_if.sv
// Data-memory bus as seen by the timer: core (master) drives strobes, timer returns data.
interface mmio_timer_resp_if;
  import mmio_timer_pkg::*;

  logic             mem_ren;
  logic             mem_wen;
  logic [REG_W-1:0] mem_addr;
  logic [REG_W-1:0] mem_wdata;
  logic [REG_W-1:0] mem_rdata;
  logic             hit;

  modport master (output mem_ren, mem_wen, mem_addr, mem_wdata,
                  input  mem_rdata, hit);
  modport slave  (input  mem_ren, mem_wen, mem_addr, mem_wdata,
                  output mem_rdata, hit);
endinterface

// File: rtl/mmio_timer_resp_tick_prescaler.sv
// Tick divider: one tick every psc+1 enabled cycles, restartable.
// Only built when MMIO_TIMER_PRESCALE_EN is defined.
`ifdef MMIO_TIMER_PRESCALE_EN
module tick_prescaler
  import mmio_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] cnt;
  logic [PSC_W-1:0] cnt_n;

  always_comb begin
    tick  = en && (cnt == psc);
    cnt_n = cnt;
    if (restart)  cnt_n = '0;
    else if (en)  cnt_n = tick ? '0 : cnt + PSC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_n;
  end

endmodule
`endif

// File: rtl/mmio_timer_resp.sv
// Memory-mapped down-counting timer on the CPU data bus with level interrupt.
// Optional prescaler register (offset 0x10) enabled by MMIO_TIMER_PRESCALE_EN.
module mmio_timer_resp
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned CNT_W     = 32
)(
  input  logic               clk,
  input  logic               rst_n,
  mmio_timer_resp_if.slave   bus,
  output logic               irq
);

  ctrl_t            ctrl,  ctrl_n;
  logic [CNT_W-1:0] load,  load_n;
  logic [CNT_W-1:0] count, count_n;
  logic             pend,  pend_n;

  logic             in_win_c;
  logic [7:0]       off_c;
  logic             wr_c, wr_ctrl_c, wr_load_c, wr_count_c, wr_stat_c;
  logic             tick_c, expire_c;
  logic [REG_W-1:0] rdata_c;

  // Window decode on the upper 24 bits; byte lane bits are dropped from the offset
  assign in_win_c   = (bus.mem_addr & 32'hFFFF_FF00) == (BASE_ADDR & 32'hFFFF_FF00);
  assign off_c      = bus.mem_addr[7:0] & 8'hFC;
  assign wr_c       = bus.mem_wen & in_win_c;
  assign wr_ctrl_c  = wr_c & (off_c == OFF_CTRL);
  assign wr_load_c  = wr_c & (off_c == OFF_LOAD);
  assign wr_count_c = wr_c & (off_c == OFF_COUNT);
  assign wr_stat_c  = wr_c & (off_c == OFF_STAT);

`ifdef MMIO_TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc;
  logic             wr_psc_c, restart_c;

  assign wr_psc_c  = wr_c & (off_c == OFF_PSC);
  assign restart_c = wr_psc_c | (wr_ctrl_c & bus.mem_wdata[CTRL_EN] & ~ctrl.en);

  tick_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ctrl.en),
    .restart (restart_c),
    .psc     (psc),
    .tick    (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        psc <= '0;
    else if (wr_psc_c) psc <= bus.mem_wdata[PSC_W-1:0];
  end
`else
  assign tick_c = ctrl.en;
`endif

  assign expire_c = tick_c && (count == '0);

  // Later assignments take priority: hw set over STAT clear, bus writes over tick effects
  always_comb begin
    ctrl_n  = ctrl;
    load_n  = load;
    count_n = count;
    pend_n  = pend;
    if (tick_c) begin
      if (count != '0)  count_n   = count - CNT_W'(1);
      else if (ctrl.ar) count_n   = load;
      else              ctrl_n.en = 1'b0;
    end
    if (wr_stat_c && bus.mem_wdata[STAT_PEND]) pend_n = 1'b0;
    if (expire_c)   pend_n  = 1'b1;
    if (wr_ctrl_c)  ctrl_n  = ctrl_t'(bus.mem_wdata[CTRL_IE:CTRL_EN]);
    if (wr_load_c)  load_n  = bus.mem_wdata[CNT_W-1:0];
    if (wr_count_c) count_n = bus.mem_wdata[CNT_W-1:0];
  end

  always_comb begin
    rdata_c = '0;
    unique case (off_c)
      OFF_CTRL:  rdata_c = REG_W'(ctrl);
      OFF_LOAD:  rdata_c = REG_W'(load);
      OFF_COUNT: rdata_c = REG_W'(count);
      OFF_STAT:  rdata_c = REG_W'(pend);
`ifdef MMIO_TIMER_PRESCALE_EN
      OFF_PSC:   rdata_c = REG_W'(psc);
`endif
      default:   rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl          <= '0;
      load          <= '0;
      count         <= '0;
      pend          <= 1'b0;
      bus.mem_rdata <= '0;
      bus.hit       <= 1'b0;
    end else begin
      ctrl          <= ctrl_n;
      load          <= load_n;
      count         <= count_n;
      pend          <= pend_n;
      bus.hit       <= bus.mem_ren & in_win_c;
      bus.mem_rdata <= (bus.mem_ren & in_win_c) ? rdata_c : '0;
    end
  end

  assign irq = pend & ctrl.ie;

endmodule

// File: tb/tb_mmio_timer_resp.sv
// Self-checking bench for mmio_timer_resp: register table, timer corner sequences,
// and randomized bus traffic against a behavioural model.
module tb_mmio_timer_resp;
  import mmio_timer_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic irq;
  int   tests = 0;
  int   failed = 0;

  mmio_timer_resp_if bus();

  mmio_timer_resp #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[23];

  // Behavioural model of the register file
  logic [31:0] m_load, m_count;
  logic        m_en, m_ar, m_ie, m_pend;
  logic [15:0] m_psc;
  longint      m_encyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.mem_ren = 1'b0; bus.mem_wen = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
  endtask

  // One bus cycle: drive at negedge, return at the following negedge with inputs idle
  task automatic op(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
    bus.mem_ren = ren; bus.mem_wen = wen; bus.mem_addr = addr; bus.mem_wdata = wdata;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    op(1'b0, 1'b1, BASE + 32'(off), d);
  endtask

  task automatic rd(input logic [7:0] off);
    op(1'b1, 1'b0, BASE + 32'(off), 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_load = '0; m_count = '0; m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_psc = '0; m_encyc = 0;
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Advance the model by one clock edge; read data reflects the state before the edge
  task automatic model_step(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] exp_rdata,
                            output logic exp_hit);
    logic       in_win, wr, tick, expire;
    logic [7:0] off;
    logic [31:0] n_count;
    logic        n_en, n_pend;
    in_win    = (addr & 32'hFFFF_FF00) == BASE;
    off       = addr[7:0] & 8'hFC;
    wr        = wen && in_win;
    exp_hit   = ren && in_win;
    exp_rdata = 32'h0;
    if (exp_hit) begin
      if (off == 8'h00)      exp_rdata = {29'h0, m_ie, m_ar, m_en};
      else if (off == 8'h04) exp_rdata = m_load;
      else if (off == 8'h08) exp_rdata = m_count;
      else if (off == 8'h0C) exp_rdata = {31'h0, m_pend};
`ifdef MMIO_TIMER_PRESCALE_EN
      else if (off == 8'h10) exp_rdata = {16'h0, m_psc};
`endif
    end
`ifdef MMIO_TIMER_PRESCALE_EN
    tick = m_en && ((m_encyc % (longint'(m_psc) + 1)) == longint'(m_psc));
`else
    tick = m_en;
`endif
    expire  = tick && (m_count == 0);
    n_count = m_count;
    n_en    = m_en;
    n_pend  = m_pend;
    if (tick && !expire) n_count = m_count - 1;
    if (expire) begin
      n_pend = 1'b1;
      if (m_ar) n_count = m_load;
      else      n_en = 1'b0;
    end
    if (wr && off == 8'h0C && wdata[0] && !expire) n_pend = 1'b0;
`ifdef MMIO_TIMER_PRESCALE_EN
    if (wr && (off == 8'h10 || (off == 8'h00 && wdata[0] && !m_en))) m_encyc = 0;
    else if (m_en) m_encyc++;
    if (wr && off == 8'h10) m_psc = wdata[15:0];
`endif
    if (wr && off == 8'h00) begin n_en = wdata[0]; m_ar = wdata[1]; m_ie = wdata[2]; end
    if (wr && off == 8'h04) m_load = wdata;
    if (wr && off == 8'h08) n_count = wdata;
    m_count = n_count;
    m_en    = n_en;
    m_pend  = n_pend;
  endtask

  task automatic random_phase(input int n);
    int          offs[6];
    logic        ren, wen, eh;
    logic [31:0] addr, wdata, er;
    logic [7:0]  off;
    offs = '{0, 4, 8, 12, 16, 32};
    for (int i = 0; i < n; i++) begin
      ren = 1'($urandom_range(0, 1));
      wen = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 8)
        addr = BASE + 32'(offs[$urandom_range(0, 5)]) + 32'($urandom_range(0, 3));
      else
        addr = $urandom;
      off = addr[7:0] & 8'hFC;
      if (off == 8'h04 || off == 8'h08) wdata = 32'($urandom_range(0, 6));
      else if (off == 8'h10)            wdata = 32'($urandom_range(0, 2));
      else                              wdata = $urandom;
      bus.mem_ren = ren; bus.mem_wen = wen; bus.mem_addr = addr; bus.mem_wdata = wdata;
      model_step(ren, wen, addr, wdata, er, eh);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_rdata", i), bus.mem_rdata, er);
      check($sformatf("rand%0d_hit", i), 32'(bus.hit), 32'(eh));
      check($sformatf("rand%0d_irq", i), 32'(irq), 32'(m_pend & m_ie));
      @(negedge clk);
    end
    bus_idle();
  endtask

  initial begin
    vecs[0]  = '{1, 0, BASE + 32'h00, 32'h0,        32'h0,        1};
    vecs[1]  = '{1, 0, BASE + 32'h04, 32'h0,        32'h0,        1};
    vecs[2]  = '{1, 0, BASE + 32'h08, 32'h0,        32'h0,        1};
    vecs[3]  = '{1, 0, BASE + 32'h0C, 32'h0,        32'h0,        1};
    vecs[4]  = '{0, 1, BASE + 32'h04, 32'hDEADBEEF, 32'h0,        0};
    vecs[5]  = '{1, 0, BASE + 32'h04, 32'h0,        32'hDEADBEEF, 1};
    vecs[6]  = '{0, 1, BASE + 32'h00, 32'hFFFFFFF8, 32'h0,        0};
    vecs[7]  = '{1, 0, BASE + 32'h00, 32'h0,        32'h0,        1};
    vecs[8]  = '{0, 1, BASE + 32'h08, 32'h5,        32'h0,        0};
    vecs[9]  = '{1, 0, BASE + 32'h08, 32'h0,        32'h5,        1};
    vecs[10] = '{1, 0, BASE + 32'h100, 32'h0,       32'h0,        0};
    vecs[11] = '{1, 0, 32'h0000_0010, 32'h0,        32'h0,        0};
    vecs[12] = '{0, 1, BASE + 32'h100, 32'h1234,    32'h0,        0};
    vecs[13] = '{0, 1, 32'h0000_0010, 32'h7,        32'h0,        0};
    vecs[14] = '{0, 1, BASE + 32'h0C, 32'h1,        32'h0,        0};
    vecs[15] = '{1, 0, BASE + 32'h07, 32'h0,        32'hDEADBEEF, 1};
    vecs[16] = '{1, 1, BASE + 32'h04, 32'h1234,     32'hDEADBEEF, 1};
    vecs[17] = '{1, 0, BASE + 32'h04, 32'h0,        32'h1234,     1};
    vecs[18] = '{1, 0, BASE + 32'h00, 32'h0,        32'h0,        1};
    vecs[19] = '{1, 0, BASE + 32'h08, 32'h0,        32'h5,        1};
    vecs[20] = '{1, 0, BASE + 32'h20, 32'h0,        32'h0,        1};
    vecs[21] = '{1, 0, BASE + 32'hFC, 32'h0,        32'h0,        1};
    vecs[22] = '{1, 0, BASE + 32'h0C, 32'h0,        32'h0,        1};

    // Reset state
    do_reset();
    check("reset_rdata", bus.mem_rdata, 32'h0);
    check("reset_hit", 32'(bus.hit), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);

    // Register access table (timer disabled throughout)
    foreach (vecs[i]) begin
      op(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), bus.mem_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_hit", i), 32'(bus.hit), 32'(vecs[i].exp_hit));
    end
`ifdef MMIO_TIMER_PRESCALE_EN
    wr(8'h10, 32'h0001_2345); rd(8'h10);
    check("psc_rw", bus.mem_rdata, 32'h0000_2345);
`else
    wr(8'h10, 32'hFFFF_FFFF); rd(8'h10);
    check("psc_absent", bus.mem_rdata, 32'h0);
`endif

    // Auto-reload: period LOAD+1, STAT clear, set-wins-over-clear
    do_reset();
    wr(8'h04, 3); wr(8'h08, 3); wr(8'h00, 7);
    idle(3);  check("ar_before_expiry", 32'(irq), 0);
    idle(1);  check("ar_first_expiry", 32'(irq), 1);
    rd(8'h08); check("ar_reloaded", bus.mem_rdata, 3);
    wr(8'h0C, 1); check("ar_clear", 32'(irq), 0);
    idle(1);  check("ar_second_before", 32'(irq), 0);
    idle(1);  check("ar_second_expiry", 32'(irq), 1);
    wr(8'h0C, 1); check("clr_after_set", 32'(irq), 0);
    idle(2);  check("clr_hold", 32'(irq), 0);
    wr(8'h0C, 1); check("set_wins_clear", 32'(irq), 1);
    wr(8'h0C, 0); check("stat_write0_noop", 32'(irq), 1);
    wr(8'h0C, 1); check("clr_next_cycle", 32'(irq), 0);
    wr(8'h00, 3); wr(8'h0C, 1); idle(4);
    check("ie_masks_irq", 32'(irq), 0);
    rd(8'h0C); check("pend_without_ie", bus.mem_rdata, 1);

    // One-shot: en clears on expiry, COUNT holds 0
    do_reset();
    wr(8'h08, 2); wr(8'h00, 5);
    idle(2); check("os_before", 32'(irq), 0);
    idle(1); check("os_expiry", 32'(irq), 1);
    rd(8'h00); check("os_ctrl", bus.mem_rdata, 32'h4);
    idle(3);
    rd(8'h08); check("os_count_hold", bus.mem_rdata, 0);
    check("os_irq_hold", 32'(irq), 1);

    // CTRL write beats expiry en-clear
    do_reset();
    wr(8'h00, 5);
    wr(8'h00, 5);
    rd(8'h00); check("ctrl_write_wins", bus.mem_rdata, 32'h5);
    rd(8'h00); check("ctrl_second_expiry", bus.mem_rdata, 32'h4);

    // COUNT write beats tick decrement
    do_reset();
    wr(8'h08, 5); wr(8'h00, 1); idle(1);
    wr(8'h08, 9);
    rd(8'h08); check("count_write_wins", bus.mem_rdata, 9);

    // Async reset mid-count with irq high and a read in flight
    do_reset();
    wr(8'h08, 0); wr(8'h04, 5); wr(8'h00, 7);
    idle(1); check("rst_pre_irq", 32'(irq), 1);
    bus.mem_ren = 1'b1; bus.mem_addr = BASE + 32'h08;
    @(posedge clk); #1;
    check("rst_pre_rdata", bus.mem_rdata, 5);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_rdata", bus.mem_rdata, 0);
    check("rst_async_hit", 32'(bus.hit), 0);
    check("rst_async_irq", 32'(irq), 0);
    @(negedge clk);
    bus_idle();
    rst_n = 1'b1;
    rd(8'h00); check("rst_ctrl", bus.mem_rdata, 0);
    rd(8'h08); check("rst_count", bus.mem_rdata, 0);
    rd(8'h0C); check("rst_stat", bus.mem_rdata, 0);

`ifdef MMIO_TIMER_PRESCALE_EN
    // PSC=1, LOAD=0, auto-reload: expiry every 2 cycles
    do_reset();
    wr(8'h10, 1); wr(8'h04, 0); wr(8'h08, 0); wr(8'h00, 7);
    idle(1); check("psc_no_tick", 32'(irq), 0);
    idle(1); check("psc_tick1", 32'(irq), 1);
    wr(8'h0C, 1); check("psc_clear1", 32'(irq), 0);
    idle(1); check("psc_tick2", 32'(irq), 1);
    wr(8'h0C, 1); check("psc_clear2", 32'(irq), 0);
    idle(1); check("psc_tick3", 32'(irq), 1);
`endif

    // Randomized traffic against the model
    do_reset();
    random_phase(400);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
